hft_zero_plus_mc: RTL and testbench
===================================

HFT_ZERO_PLUS_MC -- requirements
Module: hft_zero_plus_mc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, price/qty/position width.
REQ-002 SHALL have parameter NUM_CH, default 4, number of independent symbol channels.
REQ-003 SHALL have parameter CH_W, default 2, channel index width.
REQ-004 SHALL have parameter ORDER_QTY, default 50, quantity per BUY/SELL.
REQ-005 SHALL have parameter MAX_POS, default 100, absolute position limit per channel.
REQ-006 SHALL have parameter MAX_SPREAD, default 1, widest tradeable spread in ticks.
REQ-007 SHALL have parameter MIN_QUEUE, default 100, minimum qty for a strong queue.
REQ-008 SHALL have parameter COOLDOWN, default 8, per-channel post-order quiet cycles.
REQ-009 SHALL have ports: ap_clk in 1 clock; ap_rst in 1 asynchronous active-high reset.
REQ-010 SHALL have ports: ap_start in 1; channel in CH_W; best_bid_price, best_ask_price, best_bid_qty, best_ask_qty in DATA_WIDTH each (unsigned).
REQ-011 SHALL have ports: fill_valid in 1; fill_channel in CH_W; fill_side in 1 (0=buy, 1=sell); fill_qty in DATA_WIDTH.
REQ-012 SHALL have ports: ap_done, ap_idle, ap_ready out 1; action out 2 (0=HOLD, 1=BUY, 2=SELL); out_channel out CH_W; price, quantity out DATA_WIDTH; position out DATA_WIDTH signed; ch_err out 1.

Function
REQ-013 FSM SHALL have states IDLE, EVAL, DONE; IDLE->EVAL on ap_start, EVAL->DONE always, DONE->IDLE always.
REQ-014 In IDLE with ap_start=1, SHALL capture channel and all book inputs and pulse ap_ready for that cycle; ap_start in EVAL/DONE SHALL be ignored.
REQ-015 ap_done SHALL be high exactly in DONE, two cycles after the accepting edge; ap_idle SHALL be high only in IDLE.
REQ-016 Outputs action/out_channel/price/quantity/position/ch_err SHALL update on entry to DONE and hold until the next DONE.
REQ-017 spread SHALL be ask-bid when ask>bid; ask<=bid (crossed/locked) SHALL force HOLD.
REQ-018 BUY SHALL require: 0<spread<=MAX_SPREAD, cooldown=0, bid_qty>=MIN_QUEUE, bid_qty>ask_qty, pos+ORDER_QTY<=MAX_POS; then price=bid, quantity=ORDER_QTY.
REQ-019 SELL SHALL require: 0<spread<=MAX_SPREAD, cooldown=0, ask_qty>=MIN_QUEUE, ask_qty>bid_qty, pos-ORDER_QTY>=-MAX_POS; then price=ask, quantity=ORDER_QTY.
REQ-020 Otherwise HOLD with price=0, quantity=0; equal queues SHALL give HOLD.
REQ-021 position output SHALL be the channel position sampled in EVAL (before any same-cycle fill).
REQ-022 fill_valid SHALL add (buy) or subtract (sell) fill_qty to fill_channel's position on that edge, in every state, saturating at +/-(2^(DATA_WIDTH-1)-1).
REQ-023 Each channel cooldown counter SHALL decrement by 1 per cycle while nonzero; a BUY/SELL decision SHALL load COOLDOWN on DONE entry, load winning over decrement.
REQ-024 channel>=NUM_CH SHALL give HOLD, ch_err=1, no counter/position change; fill_channel>=NUM_CH SHALL be ignored.
REQ-025 Arithmetic SHALL use DATA_WIDTH+1 bit signed intermediates so limit checks never wrap.

Reset
REQ-026 ap_rst SHALL asynchronously force IDLE, all positions 0, all cooldowns 0, all outputs 0 except ap_idle=1.
REQ-027 Reset mid-EVAL/DONE SHALL abort without ap_done; first post-release ap_start SHALL complete normally.

Verification
REQ-028 ch0, bid 80299/ask 80300, qty 500/200, pos 0 -> ap_done at +2, action 1, price 80299, quantity 50, position 0.
REQ-029 ch1, same prices, qty 200/500 -> action 2, price 80300, quantity 50; repeat on ch1 within 8 cycles -> HOLD; after 8 cycles -> SELL.
REQ-030 ch0 ask 80301 (spread 2), qty 500/200 -> HOLD, price 0, quantity 0; ask=bid=80300 -> HOLD.
REQ-031 fill buy 100 on ch2, then ch2 BUY conditions -> HOLD, position 100; fill sell 100 on ch2 in same cycle as EVAL -> position reports 100, next eval BUY.
REQ-032 channel=5 with NUM_CH=4 -> HOLD, ch_err 1; assert ap_rst during EVAL -> no ap_done, ap_idle=1, all positions 0.

Source files
------------

// File: rtl/hft_zero_plus_mc.sv
// Multi-channel top-of-book quoting engine: takes one book snapshot per start, decides
// HOLD/BUY/SELL against per-channel position limits and cooldowns, and tracks fills.
module hft_zero_plus_mc #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2,
    parameter int ORDER_QTY  = 50,
    parameter int MAX_POS    = 100,
    parameter int MAX_SPREAD = 1,
    parameter int MIN_QUEUE  = 100,
    parameter int COOLDOWN   = 8
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic                         ap_start,
    input  logic [CH_W-1:0]              channel,
    input  logic [DATA_WIDTH-1:0]        best_bid_price,
    input  logic [DATA_WIDTH-1:0]        best_ask_price,
    input  logic [DATA_WIDTH-1:0]        best_bid_qty,
    input  logic [DATA_WIDTH-1:0]        best_ask_qty,
    input  logic                         fill_valid,
    input  logic [CH_W-1:0]              fill_channel,
    input  logic                         fill_side,
    input  logic [DATA_WIDTH-1:0]        fill_qty,
    output logic                         ap_done,
    output logic                         ap_idle,
    output logic                         ap_ready,
    output logic [1:0]                   action,
    output logic [CH_W-1:0]              out_channel,
    output logic [DATA_WIDTH-1:0]        price,
    output logic [DATA_WIDTH-1:0]        quantity,
    output logic signed [DATA_WIDTH-1:0] position,
    output logic                         ch_err
);
    localparam int W    = DATA_WIDTH;
    localparam int CD_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

    localparam logic signed [W:0]   SPREAD_MAX = (W+1)'(MAX_SPREAD);
    localparam logic signed [W:0]   ORD_QTY_X  = (W+1)'(ORDER_QTY);
    localparam logic signed [W:0]   POS_LIM    = (W+1)'(MAX_POS);
    localparam logic [W-1:0]        QUEUE_MIN  = W'(MIN_QUEUE);
    localparam logic [W-1:0]        ORD_QTY    = W'(ORDER_QTY);
    localparam logic [CD_W-1:0]     CD_LOAD    = CD_W'(COOLDOWN);
    localparam logic signed [W+1:0] SAT_MAX    = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] SAT_MIN    = -SAT_MAX;

    localparam logic [1:0] ACT_HOLD = 2'd0;
    localparam logic [1:0] ACT_BUY  = 2'd1;
    localparam logic [1:0] ACT_SELL = 2'd2;

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    state_t state, state_next;

    logic [CH_W-1:0] cap_ch;
    logic [W-1:0]    cap_bid, cap_ask, cap_bid_qty, cap_ask_qty;

    logic signed [W-1:0] pos [NUM_CH];
    logic [CD_W-1:0]     cd  [NUM_CH];

    logic                ch_ok;
    logic signed [W-1:0] cur_pos;
    logic [CD_W-1:0]     cur_cd;
    logic signed [W:0]   spread, pos_x;
    logic                spread_ok, buy_ok, sell_ok;
    logic [1:0]          dec_act;

    // Fill accumulation needs two guard bits: a full-range unsigned qty against a signed position.
    function automatic logic signed [W-1:0] sat_fill(input logic signed [W-1:0] p,
                                                     input logic sell,
                                                     input logic [W-1:0] q);
        logic signed [W+1:0] p_x, q_x, s;
        p_x = {{2{p[W-1]}}, p};
        q_x = {2'b00, q};
        s   = sell ? (p_x - q_x) : (p_x + q_x);
        if (s > SAT_MAX)      return SAT_MAX[W-1:0];
        else if (s < SAT_MIN) return SAT_MIN[W-1:0];
        else                  return s[W-1:0];
    endfunction

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        state_next = state;
        ap_ready   = 1'b0;
        case (state)
            IDLE: if (ap_start) begin
                state_next = EVAL;
                ap_ready   = !ap_rst;
            end
            EVAL:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign ap_done = (state == DONE);
    assign ap_idle = (state == IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            cap_ch      <= '0;
            cap_bid     <= '0;
            cap_ask     <= '0;
            cap_bid_qty <= '0;
            cap_ask_qty <= '0;
        end else if (state == IDLE && ap_start) begin
            cap_ch      <= channel;
            cap_bid     <= best_bid_price;
            cap_ask     <= best_ask_price;
            cap_bid_qty <= best_bid_qty;
            cap_ask_qty <= best_ask_qty;
        end
    end

    always_comb begin
        ch_ok   = 1'b0;
        cur_pos = '0;
        cur_cd  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cap_ch == CH_W'(i)) begin
                ch_ok   = 1'b1;
                cur_pos = pos[i];
                cur_cd  = cd[i];
            end
        end
    end

    assign spread    = $signed({1'b0, cap_ask}) - $signed({1'b0, cap_bid});
    assign spread_ok = !spread[W] && (spread != '0) && (spread <= SPREAD_MAX);
    assign pos_x     = {cur_pos[W-1], cur_pos};

    assign buy_ok  = spread_ok && (cur_cd == '0) && (cap_bid_qty >= QUEUE_MIN) &&
                     (cap_bid_qty > cap_ask_qty) && ((pos_x + ORD_QTY_X) <= POS_LIM);
    assign sell_ok = spread_ok && (cur_cd == '0) && (cap_ask_qty >= QUEUE_MIN) &&
                     (cap_ask_qty > cap_bid_qty) && ((pos_x - ORD_QTY_X) >= -POS_LIM);

    always_comb begin
        dec_act = ACT_HOLD;
        if (ch_ok) begin
            if (buy_ok)       dec_act = ACT_BUY;
            else if (sell_ok) dec_act = ACT_SELL;
        end
    end

    // Results are registered on the EVAL->DONE edge and held until the next decision.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            action      <= ACT_HOLD;
            out_channel <= '0;
            price       <= '0;
            quantity    <= '0;
            position    <= '0;
            ch_err      <= 1'b0;
        end else if (state == EVAL) begin
            action      <= dec_act;
            out_channel <= cap_ch;
            price       <= (dec_act == ACT_BUY)  ? cap_bid :
                           (dec_act == ACT_SELL) ? cap_ask : '0;
            quantity    <= (dec_act == ACT_HOLD) ? '0 : ORD_QTY;
            position    <= ch_ok ? cur_pos : '0;
            ch_err      <= !ch_ok;
        end
    end

    // NOTE: the per-channel arrays are architectural state, so they are reset like any register.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                pos[i] <= '0;
                cd[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (state == EVAL && cap_ch == CH_W'(i) && dec_act != ACT_HOLD)
                    cd[i] <= CD_LOAD;
                else if (cd[i] != '0)
                    cd[i] <= cd[i] - 1'b1;
                if (fill_valid && fill_channel == CH_W'(i))
                    pos[i] <= sat_fill(pos[i], fill_side, fill_qty);
            end
        end
    end

endmodule

// File: tb/tb_hft_zero_plus_mc.sv
// Directed bench for hft_zero_plus_mc: vector table for single decisions plus sequences
// for cooldown timing, fills, saturation and reset during a transaction.
module tb_hft_zero_plus_mc;
    localparam int W    = 32;
    localparam int CH_W = 3;

    logic                ap_clk = 1'b0;
    logic                ap_rst, ap_start;
    logic [CH_W-1:0]     channel, fill_channel, out_channel;
    logic [W-1:0]        best_bid_price, best_ask_price, best_bid_qty, best_ask_qty, fill_qty;
    logic                fill_valid, fill_side;
    logic                ap_done, ap_idle, ap_ready, ch_err;
    logic [1:0]          action;
    logic [W-1:0]        price, quantity;
    logic signed [W-1:0] position;

    hft_zero_plus_mc #(.DATA_WIDTH(W), .NUM_CH(4), .CH_W(CH_W)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .channel(channel),
        .best_bid_price(best_bid_price), .best_ask_price(best_ask_price),
        .best_bid_qty(best_bid_qty), .best_ask_qty(best_ask_qty),
        .fill_valid(fill_valid), .fill_channel(fill_channel), .fill_side(fill_side),
        .fill_qty(fill_qty), .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .action(action), .out_channel(out_channel), .price(price), .quantity(quantity),
        .position(position), .ch_err(ch_err)
    );

    always #5 ap_clk = ~ap_clk;

    int cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [CH_W-1:0]     ch;
        logic [W-1:0]        bid, ask, bq, aq;
        logic [1:0]          act;
        logic [W-1:0]        pr, qt;
        logic signed [W-1:0] pos;
        logic                err;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(input logic [CH_W-1:0] ch, input logic [W-1:0] bid, ask, bq, aq,
                                input logic [1:0] act, input logic [W-1:0] pr, qt,
                                input logic signed [W-1:0] pos, input logic err);
        vec_t v;
        v.ch = ch; v.bid = bid; v.ask = ask; v.bq = bq; v.aq = aq;
        v.act = act; v.pr = pr; v.qt = qt; v.pos = pos; v.err = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge ap_clk);
            #1;
        end
    endtask

    task automatic fill(input logic [CH_W-1:0] ch, input logic side, input logic [W-1:0] q);
        @(negedge ap_clk);
        fill_valid = 1'b1; fill_channel = ch; fill_side = side; fill_qty = q;
        @(posedge ap_clk);
        #1 fill_valid = 1'b0;
    endtask

    // One full transaction; start stays high through EVAL/DONE and the book is scrambled
    // after acceptance, so both must be ignored by the design.
    task automatic run(input vec_t v, input string tag, input logic fv, input logic [CH_W-1:0] fch,
                       input logic fside, input logic [W-1:0] fq, output int done_edge);
        @(negedge ap_clk);
        channel = v.ch; best_bid_price = v.bid; best_ask_price = v.ask;
        best_bid_qty = v.bq; best_ask_qty = v.aq; ap_start = 1'b1;
        #1;
        check({tag, " ready"}, ap_ready, 1);
        check({tag, " idle_before"}, ap_idle, 1);
        @(posedge ap_clk);
        #1;
        channel = v.ch ^ 3'd1; best_bid_price = v.ask; best_ask_price = v.bid;
        best_bid_qty = v.aq; best_ask_qty = v.bq;
        fill_valid = fv; fill_channel = fch; fill_side = fside; fill_qty = fq;
        check({tag, " eval_done"}, ap_done, 0);
        check({tag, " eval_idle"}, ap_idle, 0);
        check({tag, " eval_ready"}, ap_ready, 0);
        @(posedge ap_clk);
        #1;
        fill_valid = 1'b0;
        done_edge  = cyc;
        check({tag, " done"}, ap_done, 1);
        check({tag, " done_ready"}, ap_ready, 0);
        check({tag, " action"}, action, v.act);
        check({tag, " out_channel"}, out_channel, v.ch);
        check({tag, " price"}, price, v.pr);
        check({tag, " quantity"}, quantity, v.qt);
        check({tag, " position"}, position, v.pos);
        check({tag, " ch_err"}, ch_err, v.err);
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        check({tag, " idle_after"}, ap_idle, 1);
        check({tag, " done_after"}, ap_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, e3;

        vecs[0]  = mk(0, 80299, 80300, 500, 200, 1, 80299, 50, 0, 0);
        vecs[1]  = mk(1, 80299, 80300, 200, 500, 2, 80300, 50, 0, 0);
        vecs[2]  = mk(2, 80299, 80300, 300, 300, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 80299, 80301, 500, 200, 0, 0, 0, 0, 0);
        vecs[4]  = mk(0, 80300, 80300, 500, 200, 0, 0, 0, 0, 0);
        vecs[5]  = mk(0, 80301, 80300, 500, 200, 0, 0, 0, 0, 0);
        vecs[6]  = mk(0, 80299, 80300,  99,  50, 0, 0, 0, 0, 0);
        vecs[7]  = mk(2,  1000,  1001, 100,  99, 1, 1000, 50, 0, 0);
        vecs[8]  = mk(5, 80299, 80300, 500, 200, 0, 0, 0, 0, 1);
        vecs[9]  = mk(0,     5,     6, 1000, 999, 1, 5, 50, 0, 0);
        vecs[10] = mk(3,     7,     8,  99, 100, 2, 8, 50, 0, 0);

        ap_rst = 1'b1; ap_start = 1'b1; channel = '0;
        best_bid_price = '0; best_ask_price = '0; best_bid_qty = '0; best_ask_qty = '0;
        fill_valid = 1'b0; fill_channel = '0; fill_side = 1'b0; fill_qty = '0;
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst ap_done", ap_done, 0);
        check("rst ap_idle", ap_idle, 1);
        check("rst ap_ready", ap_ready, 0);
        check("rst action", action, 0);
        check("rst out_channel", out_channel, 0);
        check("rst price", price, 0);
        check("rst quantity", quantity, 0);
        check("rst position", position, 0);
        check("rst ch_err", ch_err, 0);
        @(negedge ap_clk);
        ap_start = 1'b0;
        ap_rst   = 1'b0;

        for (int i = 0; i < 11; i++)
            run(vecs[i], $sformatf("vec%0d", i), 1'b0, '0, 1'b0, '0, e);

        // Cooldown on ch1: immediate repeat and one cycle early are HOLD, later is SELL.
        wait_cyc(cyc + 10);
        run(mk(1, 80299, 80300, 200, 500, 2, 80300, 50, 0, 0), "cd1_first", 0, '0, 0, '0, e);
        run(mk(1, 80299, 80300, 200, 500, 0, 0, 0, 0, 0), "cd1_repeat", 0, '0, 0, '0, e3);
        wait_cyc(e + 6);
        run(mk(1, 80299, 80300, 200, 500, 0, 0, 0, 0, 0), "cd1_early", 0, '0, 0, '0, e3);
        run(mk(1, 80299, 80300, 200, 500, 2, 80300, 50, 0, 0), "cd1_after", 0, '0, 0, '0, e3);

        // Exact boundary: accepted eight edges after the load sees a zero cooldown.
        run(mk(3, 7, 8, 500, 200, 1, 7, 50, 0, 0), "cd3_first", 0, '0, 0, '0, e3);
        wait_cyc(e3 + 7);
        run(mk(3, 7, 8, 500, 200, 1, 7, 50, 0, 0), "cd3_boundary", 0, '0, 0, '0, e);

        // Fills on ch2, including a sell fill landing on the EVAL edge.
        wait_cyc(cyc + 10);
        fill(2, 1'b0, 100);
        run(mk(2, 1000, 1001, 500, 200, 0, 0, 0, 100, 0), "fill_limit", 1, 2, 1, 100, e);
        run(mk(2, 1000, 1001, 500, 200, 1, 1000, 50, 0, 0), "fill_after", 0, '0, 0, '0, e);
        fill(6, 1'b0, 100);
        wait_cyc(cyc + 10);
        run(mk(2, 1000, 1001, 200, 500, 2, 1001, 50, 0, 0), "fill_badch", 0, '0, 0, '0, e);

        // Short-side limit on ch3.
        wait_cyc(cyc + 10);
        fill(3, 1'b1, 80);
        run(mk(3, 7, 8, 200, 500, 0, 0, 0, -80, 0), "short_limit", 0, '0, 0, '0, e);
        fill(3, 1'b0, 30);
        run(mk(3, 7, 8, 200, 500, 2, 8, 50, -50, 0), "short_edge", 0, '0, 0, '0, e);

        // Saturation on ch0 and non-wrapping limit checks at the extremes.
        fill(0, 1'b0, 32'h7FFF_FFF0);
        fill(0, 1'b0, 32'h0000_0100);
        run(mk(0, 80299, 80300, 500, 200, 0, 0, 0, 32'sh7FFF_FFFF, 0), "sat_hi", 0, '0, 0, '0, e);
        fill(0, 1'b1, 32'hFFFF_FFFF);
        run(mk(0, 80299, 80300, 200, 500, 0, 0, 0, 32'sh8000_0001, 0), "sat_lo_sell", 0, '0, 0, '0, e);
        run(mk(0, 80299, 80300, 500, 200, 1, 80299, 50, 32'sh8000_0001, 0), "sat_lo_buy", 0, '0, 0, '0, e);

        // Reset asserted while in EVAL aborts the transaction and clears channel state.
        fill(3, 1'b0, 20);
        @(negedge ap_clk);
        channel = 0; best_bid_price = 80299; best_ask_price = 80300;
        best_bid_qty = 500; best_ask_qty = 200; ap_start = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        check("abort in_eval", ap_idle, 0);
        ap_rst = 1'b1;
        #1;
        check("abort ap_done", ap_done, 0);
        check("abort ap_idle", ap_idle, 1);
        check("abort action", action, 0);
        check("abort price", price, 0);
        check("abort quantity", quantity, 0);
        check("abort position", position, 0);
        repeat (2) @(posedge ap_clk);
        #1;
        check("abort still_not_done", ap_done, 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        run(mk(0, 80299, 80300, 500, 200, 1, 80299, 50, 0, 0), "post_rst_ch0", 0, '0, 0, '0, e);
        run(mk(3, 7, 8, 200, 500, 2, 8, 50, 0, 0), "post_rst_ch3", 0, '0, 0, '0, e);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
